// File: rtl/mos6502_pkg.sv
// Shared definitions for the 6502-class effective-address sequencer: addressing
// mode encodings, sequencer states and operand-length constants.
package mos6502_pkg;

    typedef enum logic [3:0] {
        MODE_ZP   = 4'd0,
        MODE_ZPX  = 4'd1,
        MODE_ZPY  = 4'd2,
        MODE_ABS  = 4'd3,
        MODE_ABSX = 4'd4,
        MODE_ABSY = 4'd5,
        MODE_INDX = 4'd6,
        MODE_INDY = 4'd7,
        MODE_IND  = 4'd8
    } addr_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPL,
        ST_OPH,
        ST_DUMMY,
        ST_PTRL,
        ST_PTRH,
        ST_FIX,
        ST_DONE
    } seq_state_e;

    localparam logic [1:0] OP_LEN_NONE = 2'd0;
    localparam logic [1:0] OP_LEN_ONE  = 2'd1;
    localparam logic [1:0] OP_LEN_TWO  = 2'd2;

    function automatic logic mode_is_reserved(input logic [3:0] mode);
        return mode > MODE_IND;
    endfunction

    function automatic logic mode_uses_y(input logic [3:0] mode);
        return (mode == MODE_ZPY) || (mode == MODE_ABSY) || (mode == MODE_INDY);
    endfunction

    function automatic logic [1:0] op_len_of(input logic [3:0] mode);
        case (mode)
            MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND:           return OP_LEN_TWO;
            MODE_ZP, MODE_ZPX, MODE_ZPY, MODE_INDX, MODE_INDY:  return OP_LEN_ONE;
            default:                                            return OP_LEN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mos6502_byte_adder.sv
// Byte-wide adder with carry-in and carry-out, shared by index adds,
// pointer increments and the high-byte page fix-up.
module mos6502_byte_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    logic [WIDTH:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    assign sum   = total[WIDTH-1:0];
    assign co    = total[WIDTH];

endmodule

// File: rtl/mos6502_addr_seq.sv
// Effective-address sequencer: walks indexed/indirect modes with NMOS bus timing.
// Optional macro NMOS_JMP_IND_BUG_EN keeps the JMP (ind) pointer increment inside its page.
module mos6502_addr_seq
    import mos6502_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int ZP_WRAP    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            mode,
    input  logic                  is_write,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [ADDR_WIDTH-1:0] ab,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic [1:0]            op_len,
    output logic                  page_cross,
    output logic                  err
);

    if (ADDR_WIDTH != 2 * DATA_WIDTH) begin : g_width_check
        $error("mos6502_addr_seq: ADDR_WIDTH must equal 2*DATA_WIDTH");
    end

    localparam logic [DATA_WIDTH-1:0] ZERO_BYTE = '0;

    seq_state_e            state;
    logic [3:0]            mode_r;
    logic                  wr_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] ix_r;
    logic [DATA_WIDTH-1:0] lo_r;
    logic [DATA_WIDTH-1:0] hi_r;
    logic                  cross_r;
    logic                  fixed_r;
    logic                  err_r;
    logic [1:0]            op_len_r;
    logic [ADDR_WIDTH-1:0] ea_r;

    logic [DATA_WIDTH-1:0] lo_a, lo_b, lo_sum, hi_a, hi_b, hi_sum;
    logic                  lo_ci, lo_co, hi_ci, hi_co;
    logic [ADDR_WIDTH-1:0] ea_now;

    // Page-zero high byte: either pinned to 0 or carrying the low-byte overflow.
    function automatic logic [DATA_WIDTH-1:0] zp_hi(input logic co);
        return (ZP_WRAP != 0) ? ZERO_BYTE : {{(DATA_WIDTH-1){1'b0}}, co};
    endfunction

    mos6502_byte_adder #(.WIDTH(DATA_WIDTH)) u_lo_add (
        .a(lo_a), .b(lo_b), .ci(lo_ci), .sum(lo_sum), .co(lo_co)
    );

    mos6502_byte_adder #(.WIDTH(DATA_WIDTH)) u_hi_add (
        .a(hi_a), .b(hi_b), .ci(hi_ci), .sum(hi_sum), .co(hi_co)
    );

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lo_a  = lo_r;
        lo_b  = ZERO_BYTE;
        lo_ci = 1'b0;
        case (state)
            ST_OPH, ST_DUMMY: begin
                lo_a = di;
                lo_b = ix_r;
            end
            ST_PTRL: lo_b = ix_r;
            ST_PTRH: begin
                lo_b  = (mode_r == MODE_INDX) ? ix_r : ZERO_BYTE;
                lo_ci = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        hi_a  = hi_r;
        hi_b  = ZERO_BYTE;
        hi_ci = 1'b0;
        if (state == ST_PTRH && mode_r == MODE_INDY) begin
            hi_a = di;
            hi_b = ix_r;
        end else if (state == ST_PTRH) begin
            hi_ci = lo_co;
        end else if (state == ST_DONE) begin
            hi_ci = cross_r;
        end
    end

    always_comb begin
        ab = pc_in;
        case (state)
            ST_OPL:   ab = pc_r;
            ST_OPH:   ab = pc_r + ADDR_WIDTH'(1);
            ST_DUMMY: ab = {ZERO_BYTE, di};
            ST_PTRL: begin
                if (mode_r == MODE_INDX)      ab = {zp_hi(lo_co), lo_sum};
                else if (mode_r == MODE_INDY) ab = {ZERO_BYTE, di};
                else                          ab = {di, lo_r};
            end
            ST_PTRH: begin
                if (mode_r == MODE_IND) begin
`ifdef NMOS_JMP_IND_BUG_EN
                    ab = {hi_r, lo_sum};
`else
                    ab = {hi_sum, lo_sum};
`endif
                end else begin
                    ab = {zp_hi(lo_co), lo_sum};
                end
            end
            ST_FIX:   ab = {di, lo_r};
            ST_DONE: begin
                if (err_r)                                          ab = pc_in;
                else if (mode_r == MODE_ZP)                         ab = {ZERO_BYTE, di};
                else if (mode_r == MODE_ZPX || mode_r == MODE_ZPY)  ab = {zp_hi(cross_r), lo_r};
                else if (fixed_r)                                   ab = {hi_sum, lo_r};
                else                                                ab = {di, lo_r};
            end
            default: ;
        endcase
    end

    assign ea_now     = err_r ? '0 : ab;
    assign ea         = (state == ST_DONE) ? ea_now : ea_r;
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign done       = (state == ST_DONE);
    assign err        = done && err_r;
    assign op_len     = op_len_r;
    assign page_cross = cross_r;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_r   <= '0;
            wr_r     <= 1'b0;
            pc_r     <= '0;
            ix_r     <= '0;
            lo_r     <= '0;
            hi_r     <= '0;
            cross_r  <= 1'b0;
            fixed_r  <= 1'b0;
            err_r    <= 1'b0;
            op_len_r <= OP_LEN_NONE;
            ea_r     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE) ea_r <= ea_now;
                    if (start) begin
                        pc_r     <= pc_in;
                        mode_r   <= mode;
                        wr_r     <= is_write;
                        ix_r     <= mode_uses_y(mode) ? y_in : x_in;
                        cross_r  <= 1'b0;
                        fixed_r  <= 1'b0;
                        op_len_r <= op_len_of(mode);
                        err_r    <= mode_is_reserved(mode);
                        state    <= mode_is_reserved(mode) ? ST_DONE : ST_OPL;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_OPL: begin
                    case (mode_r)
                        MODE_ZP:                       state <= ST_DONE;
                        MODE_ZPX, MODE_ZPY, MODE_INDX: state <= ST_DUMMY;
                        MODE_INDY:                     state <= ST_PTRL;
                        default:                       state <= ST_OPH;
                    endcase
                end
                ST_OPH: begin
                    if (mode_r == MODE_ABSX || mode_r == MODE_ABSY) begin
                        lo_r    <= lo_sum;
                        cross_r <= lo_co;
                        fixed_r <= lo_co | wr_r;
                        state   <= (lo_co | wr_r) ? ST_FIX : ST_DONE;
                    end else begin
                        lo_r  <= di;
                        state <= (mode_r == MODE_IND) ? ST_PTRL : ST_DONE;
                    end
                end
                ST_DUMMY: begin
                    if (mode_r == MODE_INDX) begin
                        lo_r  <= di;
                        state <= ST_PTRL;
                    end else begin
                        lo_r    <= lo_sum;
                        cross_r <= lo_co;
                        state   <= ST_DONE;
                    end
                end
                ST_PTRL: begin
                    if (mode_r == MODE_INDX)      cross_r <= lo_co;
                    else if (mode_r == MODE_INDY) lo_r    <= di;
                    else                          hi_r    <= di;
                    state <= ST_PTRH;
                end
                ST_PTRH: begin
                    if (mode_r == MODE_INDY) begin
                        lo_r    <= hi_sum;
                        cross_r <= hi_co;
                        fixed_r <= hi_co | wr_r;
                        state   <= (hi_co | wr_r) ? ST_FIX : ST_DONE;
                    end else begin
                        lo_r  <= di;
                        state <= ST_DONE;
                    end
                end
                ST_FIX: begin
                    hi_r  <= di;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mos6502_addr_seq.sv
// Directed self-checking bench for mos6502_addr_seq with a byte-wide memory model on ab/di.
module tb_mos6502_addr_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mode;
    logic        is_write;
    logic [15:0] pc_in;
    logic [7:0]  x_in, y_in, di;
    logic [15:0] ab, ea;
    logic        busy, done, page_cross, err;
    logic [1:0]  op_len;

    bit [7:0] mem [65536];
    int tests = 0;
    int failures = 0;

    mos6502_addr_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .ZP_WRAP(1)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .is_write(is_write),
        .pc_in(pc_in), .x_in(x_in), .y_in(y_in), .di(di), .ab(ab), .busy(busy),
        .done(done), .ea(ea), .op_len(op_len), .page_cross(page_cross), .err(err)
    );

    always #5 clk = ~clk;

    // Memory returns the byte for the previous cycle's address.
    always @(posedge clk) di <= mem[ab];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic launch(input logic [3:0] m, input logic [15:0] pc, input logic [7:0] x,
                          input logic [7:0] y, input logic wr);
        mode = m; pc_in = pc; x_in = x; y_in = y; is_write = wr; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        pc_in = 16'h1234;
        #1;
        chk("reset_busy", 16'(busy), 16'h0);
        chk("reset_done", 16'(done), 16'h0);
        chk("reset_ea", ea, 16'h0000);
        chk("reset_op_len", 16'(op_len), 16'h0);
        chk("reset_page_cross", 16'(page_cross), 16'h0);
        chk("reset_err", 16'(err), 16'h0);
        chk("reset_ab_follows_pc", ab, 16'h1234);
    endtask

    task automatic test_absx();
        mem[16'h0200] = 8'h20; mem[16'h0201] = 8'h30;
        launch(4'd4, 16'h0200, 8'h10, 8'h00, 1'b0);
        chk("absx_c1_ab", ab, 16'h0200);
        chk("absx_c1_busy", 16'(busy), 16'h1);
        tick();
        chk("absx_c2_ab", ab, 16'h0201);
        tick();
        chk("absx_c3_done", 16'(done), 16'h1);
        chk("absx_c3_ab", ab, 16'h3030);
        chk("absx_c3_ea", ea, 16'h3030);
        chk("absx_c3_page_cross", 16'(page_cross), 16'h0);
        chk("absx_c3_op_len", 16'(op_len), 16'h2);
        chk("absx_c3_busy", 16'(busy), 16'h0);
        tick();
        chk("absx_after_done", 16'(done), 16'h0);
        chk("absx_ea_held", ea, 16'h3030);
    endtask

    task automatic test_absx_cross();
        launch(4'd4, 16'h0200, 8'hF0, 8'h00, 1'b0);
        tick(); tick();
        chk("absx_x_c3_ab", ab, 16'h3010);
        chk("absx_x_c3_done", 16'(done), 16'h0);
        tick();
        chk("absx_x_c4_done", 16'(done), 16'h1);
        chk("absx_x_c4_ab", ab, 16'h3110);
        chk("absx_x_c4_ea", ea, 16'h3110);
        chk("absx_x_c4_page_cross", 16'(page_cross), 16'h1);
        tick();
        mem[16'h0200] = 8'h00;
        launch(4'd4, 16'h0200, 8'hF0, 8'h00, 1'b1);
        tick(); tick();
        chk("absx_w_c3_ab", ab, 16'h30F0);
        chk("absx_w_c3_done", 16'(done), 16'h0);
        tick();
        chk("absx_w_c4_done", 16'(done), 16'h1);
        chk("absx_w_c4_ea", ea, 16'h30F0);
        chk("absx_w_c4_page_cross", 16'(page_cross), 16'h0);
        tick();
    endtask

    task automatic test_indx_wrap();
        mem[16'h0300] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
        launch(4'd6, 16'h0300, 8'h01, 8'h00, 1'b0);
        tick();
        chk("indx_c2_ab", ab, 16'h00FE);
        tick();
        chk("indx_c3_ab", ab, 16'h00FF);
        tick();
        chk("indx_c4_ab", ab, 16'h0000);
        tick();
        chk("indx_c5_done", 16'(done), 16'h1);
        chk("indx_c5_ea", ea, 16'h1234);
        chk("indx_c5_op_len", 16'(op_len), 16'h1);
        tick();
    endtask

    task automatic test_ind_bug();
        logic [15:0] exp_c4, exp_ea;
`ifdef NMOS_JMP_IND_BUG_EN
        exp_c4 = 16'h3000; exp_ea = 16'h5080;
`else
        exp_c4 = 16'h3100; exp_ea = 16'h4080;
`endif
        mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h30;
        mem[16'h30FF] = 8'h80; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h40;
        launch(4'd8, 16'h0400, 8'h00, 8'h00, 1'b0);
        tick();
        chk("ind_c2_ab", ab, 16'h0401);
        tick();
        chk("ind_c3_ab", ab, 16'h30FF);
        tick();
        chk("ind_c4_ab", ab, exp_c4);
        tick();
        chk("ind_c5_done", 16'(done), 16'h1);
        chk("ind_c5_ea", ea, exp_ea);
        chk("ind_c5_op_len", 16'(op_len), 16'h2);
        tick();
    endtask

    task automatic test_reset_mid_op();
        mem[16'h0500] = 8'h40; mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h60;
        launch(4'd7, 16'h0500, 8'hAA, 8'h05, 1'b0);
        tick(); tick();
        chk("indy_c3_ab", ab, 16'h0041);
        reset = 1'b1;
        tick();
        chk("midrst_busy", 16'(busy), 16'h0);
        chk("midrst_done", 16'(done), 16'h0);
        chk("midrst_ab", ab, 16'h0500);
        chk("midrst_ea", ea, 16'h0000);
        reset = 1'b0;
        launch(4'd7, 16'h0500, 8'hAA, 8'h05, 1'b0);
        tick();
        chk("indy_c2_ab", ab, 16'h0040);
        tick(); tick();
        chk("indy_c4_done", 16'(done), 16'h1);
        chk("indy_c4_ab", ab, 16'h6005);
        chk("indy_c4_ea", ea, 16'h6005);
        tick();
    endtask

    task automatic test_reserved();
        launch(4'd12, 16'h0600, 8'h00, 8'h00, 1'b0);
        chk("rsv_done", 16'(done), 16'h1);
        chk("rsv_err", 16'(err), 16'h1);
        chk("rsv_ea", ea, 16'h0000);
        chk("rsv_ab", ab, 16'h0600);
        chk("rsv_busy", 16'(busy), 16'h0);
        chk("rsv_op_len", 16'(op_len), 16'h0);
        tick();
        chk("rsv_err_cleared", 16'(err), 16'h0);
    endtask

    task automatic test_start_while_busy();
        mem[16'h0700] = 8'h11; mem[16'h0701] = 8'h22;
        launch(4'd3, 16'h0700, 8'h00, 8'h00, 1'b0);
        start = 1'b1; pc_in = 16'h0800; mode = 4'd0;
        chk("swb_c1_ab", ab, 16'h0700);
        tick();
        chk("swb_c2_ab", ab, 16'h0701);
        start = 1'b0;
        tick();
        chk("swb_c3_done", 16'(done), 16'h1);
        chk("swb_c3_ea", ea, 16'h2211);
        tick();
        chk("swb_idle_busy", 16'(busy), 16'h0);
        chk("swb_idle_ab", ab, 16'h0800);
    endtask

    task automatic test_back_to_back();
        mem[16'h0900] = 8'h55; mem[16'h0A00] = 8'hF8;
        launch(4'd0, 16'h0900, 8'h00, 8'h00, 1'b0);
        chk("b2b_zp_c1_ab", ab, 16'h0900);
        tick();
        chk("b2b_zp_c2_done", 16'(done), 16'h1);
        chk("b2b_zp_c2_ab", ab, 16'h0055);
        launch(4'd1, 16'h0A00, 8'h10, 8'h00, 1'b0);
        chk("b2b_zpx_c1_ab", ab, 16'h0A00);
        chk("b2b_zpx_c1_busy", 16'(busy), 16'h1);
        tick();
        chk("b2b_zpx_c2_ab", ab, 16'h00F8);
        chk("b2b_zpx_c2_done", 16'(done), 16'h0);
        tick();
        chk("b2b_zpx_c3_done", 16'(done), 16'h1);
        chk("b2b_zpx_c3_ab", ab, 16'h0008);
        chk("b2b_zpx_c3_ea", ea, 16'h0008);
        chk("b2b_zpx_c3_op_len", 16'(op_len), 16'h1);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = '0; is_write = 1'b0;
        pc_in = '0; x_in = '0; y_in = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_absx();
        test_absx_cross();
        test_indx_wrap();
        test_ind_bug();
        test_reset_mid_op();
        test_reserved();
        test_start_while_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mos6502_addr_seq.md
Name: mos6502_addr_seq

Overview:
Parametrised effective-address sequencer for the 6502-class core. It takes over the address bus after DECODE and walks all indexed and indirect addressing modes with NMOS-exact bus cycles. Per mode it fetches operands and pointers, detects page crossings and inserts fix-up cycles. Its final cycle presents the effective address (EA) on ab so the core can do its data read or write in that cycle.

Parameters:
DATA_WIDTH, 8, data and index register width; page size is 2**DATA_WIDTH.
ADDR_WIDTH, 16, address width; must equal 2*DATA_WIDTH (elaboration error otherwise).
ZP_WRAP, 1, 1 means zero-page index and pointer arithmetic wraps within page 0; 0 means carry into the high byte.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin sequence; sampled only when busy=0
mode  in  4  0 ZP, 1 ZPX, 2 ZPY, 3 ABS, 4 ABSX, 5 ABSY, 6 INDX, 7 INDY, 8 IND (JMP), 9-15 reserved
is_write  in  1  store or RMW access: forces the fix-up cycle on ABSX/ABSY/INDY
pc_in  in  ADDR_WIDTH  address of first operand byte; ab follows it while idle
x_in, y_in  in  DATA_WIDTH  index registers
di  in  DATA_WIDTH  read data for the address driven on ab in the previous cycle
ab  out  ADDR_WIDTH  address bus
busy  out  1  sequence in progress (start cycle excluded)
done  out  1  one-cycle pulse; ab equals ea this cycle
ea  out  ADDR_WIDTH  effective address, valid when done=1, held until next start
op_len  out  2  operand bytes consumed (1 or 2, 0 for reserved); valid with done
page_cross  out  1  index add carried out of the low byte; valid with done
err  out  1  reserved mode; pulses with done

Behaviour:
- Reset values: busy=0, done=0, ea=0, op_len=0, page_cross=0, err=0, FSM in IDLE. In IDLE ab=pc_in combinationally.
- Reset has priority over everything and aborts any sequence mid-operation. The next cycle is IDLE.
- Start: sampled when start=1 and busy=0, latching pc_in, x_in, y_in, mode and is_write. Start while busy is ignored.
- Cycle n means the nth cycle after the start cycle. lo/hi are operand bytes, p is the ZP pointer, ix is X or Y. "+" on a byte is mod 2**DATA_WIDTH.
- ZP: c1 ab=pc; c2 done, ab={0,lo}.
- ZPX/ZPY: c1 pc; c2 {0,lo} (dummy read); c3 done, ab={0,lo+ix}. With ZP_WRAP=0 the carry goes into the high byte.
- ABS: c1 pc; c2 pc+1; c3 done, ab={hi,lo}.
- ABSX/ABSY: c1 pc; c2 pc+1; c3 ab={hi,lo+ix}.
  - No carry and is_write=0: done in c3.
  - Otherwise c4 done, ab={hi+carry,lo+ix}.
  - page_cross=carry.
- INDX: c1 pc; c2 {0,p} (dummy); c3 {0,p+X}; c4 {0,p+X+1}; c5 done, ab={di_c5,di_c4}.
- INDY: c1 pc; c2 {0,p}; c3 {0,p+1}; c4 ab={hi,lo+Y}.
  - No carry and is_write=0: done in c4.
  - Otherwise c5 done, ab={hi+carry,lo+Y}.
- IND: c1 pc; c2 pc+1; c3 ptr={hi,lo}; c4 ptr+1 (full ADDR_WIDTH add unless bug mode); c5 done, ab=target.
- Reserved modes: c1 done with err=1, ea=0, ab=pc_in.
- op_len: 2 for ABS/ABSX/ABSY/IND, 1 for the other legal modes.
- High-byte fix-up wraps at 2**ADDR_WIDTH, so {FF,FF}+1 gives 0000.
- After done the FSM returns to IDLE. start may be sampled in the done cycle (back-to-back) only if busy=0, and busy deasserts in the done cycle.
- FSM states: IDLE, OPL, OPH, DUMMY, PTRL, PTRH, FIX, DONE. Transitions follow the per-mode sequences above.

Optional Feature:
Macro NMOS_JMP_IND_BUG_EN.
- Defined: IND c4 address is {ptr_hi, ptr_lo+1}; the high byte never increments, reproducing the NMOS page-wrap bug.
- Undefined: c4 is ptr+1 over the full ADDR_WIDTH (CMOS behaviour).

Decomposition:
Shared package mos6502_pkg holds:
- mode encodings;
- FSM state enum;
- op_len constants.

Natural sub-module: mos6502_byte_adder, a DATA_WIDTH adder with carry-in and carry-out. It is reused for index add, pointer+1 and the high-byte fix-up.

Test Plan:
1. ABSX: mode=4, X=0x10, mem[pc..]=0x20,0x30, is_write=0 -> ab c3=0x3030, done c3, page_cross=0, op_len=2.
2. ABSX page cross: X=0xF0, operands 0x20,0x30 -> c3 ab=0x3010; c4 done, ab=ea=0x3110, page_cross=1. Repeat with lo=0x00 and is_write=1 -> done c4, ea=0x30F0.
3. INDX wrap: p=0xFE, X=0x01, mem[0x00FF]=0x34, mem[0x0000]=0x12 -> c3 ab=0x00FF, c4 ab=0x0000, c5 ea=0x1234.
4. IND bug: ptr=0x30FF, mem[0x30FF]=0x80, mem[0x3000]=0x50, mem[0x3100]=0x40 -> ea=0x5080 with macro defined, 0x4080 without.
5. Reset mid-op: assert reset in c3 of INDY -> next cycle busy=0, done=0, ab=pc_in. A start issued after reset deasserts completes normally.
6. Reserved and back-to-back: mode=12 -> c1 done, err=1, ea=0. A start held high while busy is ignored. ZP followed by ZPX gives done in c2 then done in c3 of the second sequence.
